// File: rtl/tage_pkg.sv
// Shared types and constants for the TAGE base (T0) bimodal table update path.
package tage_pkg;

    localparam int T0_ENTRIES = 512;
    localparam int T0_IDX_W   = $clog2(T0_ENTRIES);

    typedef logic [1:0] ctr2_t;

    // Reset value every T0 counter should hold after the init sweep.
    localparam ctr2_t CTR_WEAK_NT = 2'b01;
    // The sweep presents one below weak-NT with taken=1; T0's own increment lands on weak-NT.
    localparam ctr2_t CTR_SWEEP_PRED = CTR_WEAK_NT - 2'd1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        ctr2_t       pred;
    } t0_upd_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } t0_state_e;

endpackage

// File: rtl/tage_t0_update_ctrl_if.sv
// Commit-side update ports and T0 write-port bundle for the T0 update sequencer.
interface tage_t0_update_ctrl_if import tage_pkg::*; ();

    logic        upd0_valid;
    logic        upd0_ready;
    logic [31:0] upd0_pc;
    logic        upd0_taken;
    ctr2_t       upd0_pred;

    logic        upd1_valid;
    logic        upd1_ready;
    logic [31:0] upd1_pc;
    logic        upd1_taken;
    ctr2_t       upd1_pred;

    logic        t0_update_valid;
    logic [31:0] t0_update_pc;
    logic        t0_update_taken;
    ctr2_t       t0_update_pred;

    // Commit unit side: issues updates, observes readies and the T0 write stream.
    modport master (
        output upd0_valid, upd0_pc, upd0_taken, upd0_pred,
        output upd1_valid, upd1_pc, upd1_taken, upd1_pred,
        input  upd0_ready, upd1_ready,
        input  t0_update_valid, t0_update_pc, t0_update_taken, t0_update_pred
    );

    // Sequencer side.
    modport slave (
        input  upd0_valid, upd0_pc, upd0_taken, upd0_pred,
        input  upd1_valid, upd1_pc, upd1_taken, upd1_pred,
        output upd0_ready, upd1_ready,
        output t0_update_valid, t0_update_pc, t0_update_taken, t0_update_pred
    );

endinterface

// File: rtl/tage_upd_fifo.sv
// Two-write / one-read update FIFO. Port 0 is always written ahead of port 1.
module tage_upd_fifo import tage_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push0,
    input  t0_upd_t                    data0,
    input  logic                       push1,
    input  t0_upd_t                    data1,
    input  logic                       pop,
    output t0_upd_t                    head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    t0_upd_t          mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wslot1;

    // Port 1 lands in the slot after port 0 when both write, otherwise in the next free slot.
    always_comb begin
        wslot1 = push0 ? wptr + PTR_W'(1) : wptr;
    end

    // Pointers and occupancy; flush drops everything including a same-cycle push.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PTR_W'(push0) + PTR_W'(push1);
            rptr  <= rptr + PTR_W'(pop);
            count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    // Entry storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push0) mem[wptr]   <= data0;
        if (push1) mem[wslot1] <= data1;
    end

    assign head = mem[rptr];

endmodule

// File: rtl/tage_t0_update_ctrl.sv
// T0 update sequencer: init sweep of the bimodal table, then drains buffered
// branch-resolution updates from two commit ports at one per cycle.
module tage_t0_update_ctrl import tage_pkg::*; #(
    parameter int NUM_ENTRIES = T0_ENTRIES,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        reinit,
    tage_t0_update_ctrl_if.slave        upd,
    output logic                        init_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    t0_state_e        state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] count;
    t0_upd_t          head, wr0, wr1;
    logic             push0, push1, pop, flush;
    logic             ready0, ready1;
    logic             sweep_last;

    assign sweep_last = (idx == IDX_W'(NUM_ENTRIES - 1));
    assign wr0 = '{pc: upd.upd0_pc, taken: upd.upd0_taken, pred: upd.upd0_pred};
    assign wr1 = '{pc: upd.upd1_pc, taken: upd.upd1_taken, pred: upd.upd1_pred};
    assign upd.upd0_ready = ready0;
    assign upd.upd1_ready = ready1;

    // State and sweep index; reset always restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next state, FIFO control and T0 output mux; everything is gated while in reset.
    always_comb begin
        state_nxt           = state;
        idx_nxt             = idx;
        flush               = 1'b0;
        push0               = 1'b0;
        push1               = 1'b0;
        pop                 = 1'b0;
        ready0              = 1'b0;
        ready1              = 1'b0;
        init_busy           = 1'b1;
        fifo_count          = '0;
        upd.t0_update_valid = 1'b0;
        upd.t0_update_pc    = '0;
        upd.t0_update_taken = 1'b0;
        upd.t0_update_pred  = CTR_SWEEP_PRED;
        if (rst_n) begin
            case (state)
                ST_INIT: begin
                    upd.t0_update_valid = 1'b1;
                    upd.t0_update_pc    = 32'(idx);
                    upd.t0_update_taken = 1'b1;
                    upd.t0_update_pred  = CTR_SWEEP_PRED;
                    idx_nxt             = idx + IDX_W'(1);
                    if (sweep_last) begin
                        state_nxt = ST_RUN;
                        idx_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    init_busy           = 1'b0;
                    fifo_count          = count;
                    ready0              = (count < CNT_W'(FIFO_DEPTH));
                    ready1              = (count <= CNT_W'(FIFO_DEPTH - 2));
                    push0               = upd.upd0_valid && ready0;
                    push1               = upd.upd1_valid && ready1;
                    pop                 = (count != '0);
                    upd.t0_update_valid = pop;
                    upd.t0_update_pc    = head.pc;
                    upd.t0_update_taken = head.taken;
                    upd.t0_update_pred  = head.pred;
                    if (reinit) begin
                        state_nxt = ST_INIT;
                        idx_nxt   = '0;
                        flush     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    tage_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push0 (push0),
        .data0 (wr0),
        .push1 (push1),
        .data1 (wr1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_tage_t0_update_ctrl.sv
// Scoreboard bench for tage_t0_update_ctrl: the driver predicts the T0 write
// stream from the block's rules, the monitor checks it against the DUT.
module tb_tage_t0_update_ctrl;

    localparam int N = 512;
    localparam int D = 4;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [1:0]  pred;
        bit          sweep;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reinit;
    logic       init_busy;
    logic [2:0] fifo_count;

    tage_t0_update_ctrl_if bus ();

    tage_t0_update_ctrl #(
        .NUM_ENTRIES (N),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reinit     (reinit),
        .upd        (bus.slave),
        .init_busy  (init_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Expected T0 write stream: sweep entries during init, else buffered updates in order.
    exp_t exp_q[$];
    exp_t stg_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Block is busy (init or reset) when in reset or while sweep writes remain.
    function automatic bit m_init();
        return !rst_n || (exp_q.size() != 0 && exp_q[0].sweep);
    endfunction

    function automatic exp_t rand_e();
        exp_t e;
        e.pc    = $urandom;
        e.taken = 1'($urandom_range(0, 1));
        e.pred  = 2'($urandom_range(0, 3));
        e.sweep = 1'b0;
        return e;
    endfunction

    task automatic push_sweep();
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e.pc = 32'(i); e.taken = 1'b1; e.pred = 2'b00; e.sweep = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one T0 write per cycle leaves the model whenever it holds entries.
    always @(negedge clk) begin
        bit   busy;
        int   sz;
        exp_t e;
        busy = m_init();
        sz   = exp_q.size();
        check("t0_valid",   32'(bus.t0_update_valid), 32'(sz != 0));
        check("init_busy",  32'(init_busy),           32'(busy));
        check("upd0_ready", 32'(bus.upd0_ready),      32'(!busy && sz < D));
        check("upd1_ready", 32'(bus.upd1_ready),      32'(!busy && sz <= D - 2));
        check("fifo_count", 32'(fifo_count),          32'(busy ? 0 : sz));
        if (sz != 0) begin
            e = exp_q.pop_front();
            if (bus.t0_update_valid === 1'b1) begin
                check("t0_pc",    bus.t0_update_pc,           e.pc);
                check("t0_taken", 32'(bus.t0_update_taken),   32'(e.taken));
                check("t0_pred",  32'(bus.t0_update_pred),    32'(e.pred));
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input bit v0, input exp_t e0, input bit v1, input exp_t e1, input bit ri);
        bit busy;
        int sz;
        bit do_flush;
        busy     = m_init();
        sz       = exp_q.size();
        do_flush = 1'b0;
        bus.upd0_valid = v0; bus.upd0_pc = e0.pc; bus.upd0_taken = e0.taken; bus.upd0_pred = e0.pred;
        bus.upd1_valid = v1; bus.upd1_pc = e1.pc; bus.upd1_taken = e1.taken; bus.upd1_pred = e1.pred;
        reinit = ri;
        stg_q.delete();
        if (!busy) begin
            if (ri) do_flush = 1'b1;
            else begin
                if (v0 && sz < D)      stg_q.push_back(e0);
                if (v1 && sz <= D - 2) stg_q.push_back(e1);
            end
        end
        @(posedge clk); #1;
        if (do_flush) begin
            exp_q.delete();
            push_sweep();
        end else begin
            foreach (stg_q[i]) exp_q.push_back(stg_q[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rand_e(), 1'b0, rand_e(), 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        reinit = 1'b0;
        bus.upd0_valid = 1'b0;
        bus.upd1_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        push_sweep();
    endtask

    task automatic wait_sweep();
        int k;
        k = 0;
        while (m_init() && k < N + 100) begin
            step(1'($urandom_range(0, 1)), rand_e(), 1'($urandom_range(0, 1)), rand_e(), 1'b0);
            k++;
        end
        if (m_init()) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: still busy after %0d cycles, expected done", k);
        end
    endtask

    initial begin
        exp_t a, b;
        rst_n = 1'b0;
        reinit = 1'b0;
        bus.upd0_valid = 1'b0; bus.upd0_pc = '0; bus.upd0_taken = 1'b0; bus.upd0_pred = '0;
        bus.upd1_valid = 1'b0; bus.upd1_pc = '0; bus.upd1_taken = 1'b0; bus.upd1_pred = '0;

        // Power-on sweep.
        do_reset(2);
        wait_sweep();

        // Single port-0 update.
        a.pc = 32'h104; a.taken = 1'b1; a.pred = 2'b10; a.sweep = 1'b0;
        step(1'b1, a, 1'b0, rand_e(), 1'b0);
        idle(2);

        // Both ports at once, then idle.
        step(1'b1, rand_e(), 1'b1, rand_e(), 1'b0);
        idle(4);

        // Sustained pressure on both ports.
        for (int i = 0; i < 4; i++) step(1'b1, rand_e(), 1'b1, rand_e(), 1'b0);
        idle(6);

        // Three queued, then reinit.
        step(1'b1, rand_e(), 1'b1, rand_e(), 1'b0);
        step(1'b1, rand_e(), 1'b1, rand_e(), 1'b0);
        step(1'b1, rand_e(), 1'b1, rand_e(), 1'b1);

        // Reinit mid-sweep is ignored; reset at idx 200 restarts the sweep.
        idle(100);
        step(1'b0, rand_e(), 1'b0, rand_e(), 1'b1);
        idle(99);
        do_reset(2);
        wait_sweep();

        // Random traffic with occasional reinit.
        for (int i = 0; i < 1500; i++) begin
            b = rand_e();
            step(1'($urandom_range(0, 9) < 7), rand_e(), 1'($urandom_range(0, 9) < 6), b,
                 1'($urandom_range(0, 199) == 0));
        end
        if (m_init()) wait_sweep();
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
